// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Boot-time program loader placed in front of the core's instruction memory.
// A byte stream arrives over a valid/ready handshake. It starts with a
// big-endian 16-bit word count N, followed by N big-endian 32-bit words.
// Each word is written to consecutive word addresses starting at BASE_ADDR.
// core_run is raised once the whole image has been written.
//
// Optional build macro: LOADER_CHECKSUM_EN
//   When this macro is defined, one extra byte follows the payload. That byte
//   must equal the XOR of every preceding byte, including the length bytes.
//   If it does not match, the load ends in ERROR. Words already written stay
//   in memory, but core_run is not raised.
//
// Parameters:
//   BASE_ADDR     byte address of the first word (must be 4-aligned)
//   MAX_WORDS     largest accepted image in words (<= 65535)
//
// Ports:
//   clock         system clock, rising-edge active
//   reset_n       synchronous active-low reset
//   start         one-cycle pulse; begins a load from IDLE, DONE or ERROR
//   in_valid      in_data holds a byte
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle
//   imem_we       instruction-memory write strobe (one cycle per word)
//   imem_addr     byte address of the pending or last write
//   imem_wdata    word being written
//   core_run      image complete; core may fetch
//   busy          load in progress
//   error         load aborted
//   words_loaded  words written in the current or last load
// -----------------------------------------------------------------------------
// state  | meaning
// IDLE   | waiting for start after reset
// LEN_HI | expecting length byte [15:8]
// LEN_LO | expecting length byte [7:0]
// WORD   | assembling payload words, 4 bytes each, MSB first
// CHK    | expecting checksum byte (LOADER_CHECKSUM_EN only)
// DONE   | image complete, core_run once the final write has retired
// ERROR  | load aborted, waiting for start
// -----------------------------------------------------------------------------
module instr_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_run,
    output logic        busy,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        WORD,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERROR
    } state_t;

    // The state entered once the payload (or an empty image) has been consumed.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHK;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t      state, state_nx;
    logic [15:0] len_q;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] shift_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  xor_q;
`endif

    logic        xfer;
    logic        start_ok;
    logic        last_word;
    logic [15:0] len_full;

    assign busy      = (state == LEN_HI) || (state == LEN_LO) || (state == WORD)
`ifdef LOADER_CHECKSUM_EN
                       || (state == CHK)
`endif
                       ;
    assign in_ready  = busy;
    assign error     = (state == ERROR);
    // The final word is registered on the same edge that enters DONE.
    // Holding core_run low while that write is still pending keeps the core
    // from starting until the image is actually in memory.
    assign core_run  = (state == DONE) && !imem_we;

    assign xfer      = in_valid && in_ready;
    assign start_ok  = start && !busy;
    assign len_full  = {len_q[15:8], in_data};
    assign last_word = (word_idx == len_q - 16'd1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) state_nx = LEN_LO;
            end
            LEN_LO: begin
                if (xfer) begin
                    if (len_full == 16'd0)
                        state_nx = END_STATE;
                    else if (len_full > MAX_LEN)
                        state_nx = ERROR;
                    else
                        state_nx = WORD;
                end
            end
            WORD: begin
                if (xfer && (byte_cnt == 2'd3) && last_word) state_nx = END_STATE;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) state_nx = (in_data == xor_q) ? DONE : ERROR;
            end
`endif
            DONE, ERROR: begin
                if (start) state_nx = LEN_HI;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            len_q        <= '0;
            word_idx     <= '0;
            byte_cnt     <= '0;
            shift_q      <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= '0;
            words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q        <= '0;
`endif
        end else begin
            state   <= state_nx;
            imem_we <= 1'b0;
            if (start_ok) begin
                len_q        <= '0;
                word_idx     <= '0;
                byte_cnt     <= '0;
                imem_addr    <= BASE_ADDR;
                words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
                xor_q        <= '0;
`endif
            end else begin
                if (imem_we) words_loaded <= words_loaded + 16'd1;
                if (xfer) begin
                    case (state)
                        LEN_HI: len_q[15:8] <= in_data;
                        LEN_LO: len_q[7:0]  <= in_data;
                        WORD: begin
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {shift_q, in_data};
                                word_idx   <= word_idx + 16'd1;
                                // The address points at the pending write, so it
                                // only moves on after the first word of a load.
                                if (word_idx != 16'd0) imem_addr <= imem_addr + 32'd4;
                            end else begin
                                shift_q <= {shift_q[15:0], in_data};
                            end
                        end
                        default: ;
                    endcase
`ifdef LOADER_CHECKSUM_EN
                    if (state != CHK) xor_q <= xor_q ^ in_data;
`endif
                end
            end
        end
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time program loader sitting directly upstream of the single-cycle core's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word addresses starting at BASE_ADDR.
- Raises core_run once the whole image is loaded. The core's PC register must be gated by core_run, so the core only executes from a complete image.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction written; must be 4-aligned.
- MAX_WORDS, 1024, largest image accepted, in words; must be ≤ 65535.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load.
- in_valid  in  1  in_data holds a byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  32  byte address for the write.
- imem_wdata  out  32  instruction word to write.
- core_run  out  1  image complete; core may fetch.
- busy  out  1  load in progress.
- error  out  1  load aborted.
- words_loaded  out  16  number of words written in the current or last load.

Behaviour:
- Reset (reset_n=0 at a clock edge) drives all outputs to 0, imem_addr to BASE_ADDR, and the FSM to IDLE. Reset mid-load discards any partial word and count.
- A byte transfer occurs on an edge where in_valid && in_ready.
- in_ready=1 only in LEN_HI, LEN_LO, WORD and CHK; it is 0 in IDLE, DONE and ERROR.
- FSM states: IDLE, LEN_HI, LEN_LO, WORD, CHK (feature only), DONE, ERROR.
- IDLE: start moves to LEN_HI and clears words_loaded, core_run and error. busy=1 in every state except IDLE, DONE and ERROR.
- LEN_HI / LEN_LO: capture a 16-bit word count N, big-endian.
  - After LEN_LO: N==0 goes to DONE (no writes).
  - N > MAX_WORDS goes to ERROR.
  - Otherwise go to WORD.
- WORD: bytes are shifted in MSB first (byte 0 → bits 31:24).
  - On the edge accepting the 4th byte, the assembled word is registered, so imem_we=1 with imem_wdata/imem_addr valid during the following cycle only.
  - in_ready stays 1 during that write cycle, giving back-to-back words at one byte per cycle with no bubbles.
- After each write: imem_addr += 4, wrapping modulo 2^32, and words_loaded += 1.
  - imem_addr holds the address of the pending or last write.
  - The first write uses BASE_ADDR.
- After the Nth word is assembled, the write cycle still occurs. The FSM enters DONE (or CHK with the feature) on the same edge the word is registered.
- DONE: core_run=1, asserted in the cycle after the final write cycle; for N==0, in the cycle after LEN_LO is accepted.
- ERROR: error=1 and core_run=0 until the next start or reset.
- start while busy=1 is ignored.
- start in DONE or ERROR begins a new load: core_run/error fall on the next edge and imem_addr returns to BASE_ADDR.
- Bytes presented while in_ready=0 are not consumed; the upstream must hold them.
- Simultaneous start and in_valid in IDLE: only start takes effect; the byte is not consumed.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the last payload byte (or after LEN_LO when N==0) the FSM enters CHK and accepts one byte.
  - If it equals the XOR of all preceding bytes (length bytes included), go to DONE; otherwise go to ERROR.
  - Data words are still written to memory on mismatch; core_run stays 0.
- Undefined: CHK state and XOR register are absent; the payload end goes directly to DONE.

Test Plan:
- Reset, start, stream 00 02 24 08 00 05 AC 08 00 00 at one byte per cycle:
  - imem_we pulses twice: addr 0x0 data 0x24080005, then addr 0x4 data 0xAC080000.
  - words_loaded=2; core_run rises in the cycle after the second write; in_ready stays high through the writes.
- Same image with in_valid toggling 1/0 each cycle: identical writes, with no byte dropped or duplicated.
- Length 0x0401 (1025 > MAX_WORDS): ERROR after LEN_LO, error=1, no imem_we, core_run=0. A later start recovers.
- Reset_n pulled low after 6 of 10 bytes: all outputs 0, no further writes. A fresh start then reloads correctly from BASE_ADDR.
- start pulsed during WORD: ignored; the load completes normally with words_loaded equal to N.
- LOADER_CHECKSUM_EN defined, stream 00 01 11 22 33 44 followed by checksum 45:
  - Correct checksum 45 → DONE, core_run=1.
  - Checksum 46 → word 0x11223344 is still written, error=1, core_run=0.
